resblock_fwd_ctrl: RTL and testbench

- Sequences the residual-block skip-connection reads for the 4-bank interleaved activation SRAM.
- Each SRAM word holds a 2x2 pixel block for all CH_NUM channels. Bank parity is {block_y[0], block_x[0]}, with b0=00, b1=01, b2=10, b3=11.
- For every 2x2 output window, the block issues one read to all four banks. It then steps the channel index and applies the 4-cycle delay, which produces map_type_delay4, fmap_idx_delay4 and the latch strobe consumed by the forwarding mux.

---
 rtl/resblock_fwd_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_resblock_fwd_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resblock_fwd_ctrl.sv
// resblock_fwd_ctrl
// Sequences the residual-block skip-connection reads from the 4-bank
// interleaved activation SRAM. One read per 2x2 output window covers all four
// banks. The channel index is then swept one per cycle and pushed through a
// fixed 4-stage delay line that feeds the forwarding mux.
//
// Handshake / flow control: there is no valid/ready pair here. i_start is a
// single-cycle request honoured only in IDLE. i_stall is a pure hold: while it
// is high in RUN or DRAIN every register keeps its value, and the strobes
// o_sram_rd_en / o_rdata_latch_en are forced low. In IDLE and DONE i_stall
// has no effect.
module resblock_fwd_ctrl #(
  parameter int CH_NUM  = 24,
  parameter int BLK_BW  = 7,
  parameter int ADDR_BW = 10
) (
  input  logic               i_clk,
  input  logic               i_srst,
  input  logic               i_start,
  input  logic [BLK_BW-1:0]  i_cfg_blk_num,
  input  logic               i_stall,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_sram_rd_en,
  output logic [ADDR_BW-1:0] o_sram_raddr_b0,
  output logic [ADDR_BW-1:0] o_sram_raddr_b1,
  output logic [ADDR_BW-1:0] o_sram_raddr_b2,
  output logic [ADDR_BW-1:0] o_sram_raddr_b3,
  output logic               o_rdata_latch_en,
  output logic [1:0]         o_map_type_delay4,
  output logic [6:0]         o_fmap_idx_delay4,
  output logic               o_fwd_valid_delay4,
  output logic [1:0]         o_dbg_state
);

  // Depth of the forwarding delay line; the *_delay4 names assume 4.
  localparam int FWD_DELAY = 4;
  localparam int YW        = BLK_BW + 1;
  localparam int PW        = 2 * BLK_BW + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BLK_BW-1:0] r_blk;
  logic [BLK_BW-1:0] r_row;
  logic [BLK_BW-1:0] r_wy;
  logic [BLK_BW-1:0] r_wx;
  logic [BLK_BW-1:0] w_lim;
  logic [BLK_BW-1:0] w_cfg_row;
  logic [6:0]        r_ch;
  logic [2:0]        r_drain_cnt;

  logic w_hold;
  logic w_adv;
  logic w_valid_s0;
  logic w_ch_last;
  logic w_wx_last;
  logic w_wy_last;
  logic w_last;
  logic w_drain_last;

  logic [FWD_DELAY-1:0]      r_pv;
  logic [FWD_DELAY-1:0]      r_pl;
  logic [FWD_DELAY-1:0][1:0] r_pmap;
  logic [FWD_DELAY-1:0][6:0] r_pidx;

  // Bank address for parity (py,px): step the window corner onto the block
  // row/column of that parity, then linearise with the row pitch.
  function automatic logic [ADDR_BW-1:0] f_addr(
    input logic [BLK_BW-1:0] wy,
    input logic [BLK_BW-1:0] wx,
    input logic [BLK_BW-1:0] row,
    input logic              py,
    input logic              px
  );
    logic [YW-1:0] y;
    logic [YW-1:0] x;
    y = (wy[0] == py) ? YW'(wy) : YW'(wy) + YW'(1);
    x = (wx[0] == px) ? YW'(wx) : YW'(wx) + YW'(1);
    return ADDR_BW'(PW'(y >> 1) * PW'(row) + PW'(x >> 1));
  endfunction

  // Row pitch of the bank arrays: ceil(blk/2), taken from the incoming config.
  assign w_cfg_row    = BLK_BW'((YW'(i_cfg_blk_num) + YW'(1)) >> 1);

  assign w_hold       = i_stall && (r_state == S_RUN || r_state == S_DRAIN);
  assign w_adv        = !w_hold;
  assign w_valid_s0   = (r_state == S_RUN) && !i_stall;
  assign w_lim        = r_blk - BLK_BW'(2);
  assign w_ch_last    = (r_ch == 7'(CH_NUM - 1));
  assign w_wx_last    = (r_wx == w_lim);
  assign w_wy_last    = (r_wy == w_lim);
  assign w_last       = w_ch_last && w_wx_last && w_wy_last;
  assign w_drain_last = (r_drain_cnt == 3'(FWD_DELAY - 1));

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_srst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and the state-derived control outputs.
  always_comb begin
    w_state_nxt  = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_sram_rd_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_cfg_blk_num < BLK_BW'(2)) w_state_nxt = S_DONE;
          else                            w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        o_busy       = 1'b1;
        o_sram_rd_en = w_valid_s0 && (r_ch == 7'd0);
        if (w_valid_s0 && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (!i_stall && w_drain_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config latch and window/channel counters (ch fastest, then wx, then wy).
  // The counters wrap back to zero after the last window so idle addresses read 0.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_blk <= '0;
      r_row <= '0;
      r_wy  <= '0;
      r_wx  <= '0;
      r_ch  <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_blk <= i_cfg_blk_num;
      r_row <= w_cfg_row;
      r_wy  <= '0;
      r_wx  <= '0;
      r_ch  <= '0;
    end else if (w_valid_s0) begin
      if (w_ch_last) begin
        r_ch <= '0;
        if (w_wx_last) begin
          r_wx <= '0;
          r_wy <= w_wy_last ? '0 : r_wy + BLK_BW'(1);
        end else begin
          r_wx <= r_wx + BLK_BW'(1);
        end
      end else begin
        r_ch <= r_ch + 7'd1;
      end
    end
  end

  // Drain counter: counts non-stalled DRAIN cycles.
  always_ff @(posedge i_clk) begin
    if (i_srst)                              r_drain_cnt <= '0;
    else if (r_state != S_DRAIN)             r_drain_cnt <= '0;
    else if (!i_stall)                       r_drain_cnt <= r_drain_cnt + 3'd1;
  end

  // Forwarding delay line; bubbles enter whenever stage 0 is not valid.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_pv   <= '0;
      r_pl   <= '0;
      r_pmap <= '0;
      r_pidx <= '0;
    end else if (w_adv) begin
      r_pv   <= {r_pv[FWD_DELAY-2:0], w_valid_s0};
      r_pl   <= {r_pl[FWD_DELAY-2:0], w_valid_s0 && (r_ch == 7'd0)};
      r_pmap <= {r_pmap[FWD_DELAY-2:0], (w_valid_s0 ? {r_wy[0], r_wx[0]} : 2'b00)};
      r_pidx <= {r_pidx[FWD_DELAY-2:0], (w_valid_s0 ? r_ch : 7'd0)};
    end
  end

  assign o_sram_raddr_b0    = f_addr(r_wy, r_wx, r_row, 1'b0, 1'b0);
  assign o_sram_raddr_b1    = f_addr(r_wy, r_wx, r_row, 1'b0, 1'b1);
  assign o_sram_raddr_b2    = f_addr(r_wy, r_wx, r_row, 1'b1, 1'b0);
  assign o_sram_raddr_b3    = f_addr(r_wy, r_wx, r_row, 1'b1, 1'b1);

  // The latch strobe comes one stage early so the bank data is registered
  // exactly when its ch=0 entry reaches the delay4 outputs.
  assign o_rdata_latch_en   = r_pl[FWD_DELAY-2] && w_adv;
  assign o_fwd_valid_delay4 = r_pv[FWD_DELAY-1];
  assign o_map_type_delay4  = r_pmap[FWD_DELAY-1];
  assign o_fmap_idx_delay4  = r_pidx[FWD_DELAY-1];
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_resblock_fwd_ctrl.sv
// Testbench for resblock_fwd_ctrl: randomized runs checked cycle by cycle
// against a queue-based sequence model, plus fixed-value window checks.
module tb_resblock_fwd_ctrl;

  localparam int CH       = 24;
  localparam int SW       = 54;
  localparam int B_FV     = 0;
  localparam int B_LATCH  = 10;
  localparam int B_RD     = 51;
  localparam int B_DONE   = 52;
  localparam int B_BUSY   = 53;
  localparam logic [1:0] IDLE_CODE = 2'd0;

  typedef logic [SW-1:0] snap_t;
  typedef struct packed {
    logic [1:0]  map;
    logic [6:0]  ch;
    logic [39:0] addrs;
  } item_t;
  typedef struct packed {
    logic       v;
    logic [1:0] map;
    logic [6:0] idx;
    logic       l;
  } hist_t;

  logic       clk;
  logic       i_srst;
  logic       i_start;
  logic [6:0] i_cfg_blk_num;
  logic       i_stall;
  logic       o_busy;
  logic       o_done;
  logic       o_sram_rd_en;
  logic [9:0] o_sram_raddr_b0;
  logic [9:0] o_sram_raddr_b1;
  logic [9:0] o_sram_raddr_b2;
  logic [9:0] o_sram_raddr_b3;
  logic       o_rdata_latch_en;
  logic [1:0] o_map_type_delay4;
  logic [6:0] o_fmap_idx_delay4;
  logic       o_fwd_valid_delay4;
  logic [1:0] o_dbg_state;

  snap_t      exp_q[$];
  snap_t      obs_q[$];
  logic [1:0] st_q[$];
  int         n_tests;
  int         n_fail;

  resblock_fwd_ctrl dut (
    .i_clk              (clk),
    .i_srst             (i_srst),
    .i_start            (i_start),
    .i_cfg_blk_num      (i_cfg_blk_num),
    .i_stall            (i_stall),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_sram_rd_en       (o_sram_rd_en),
    .o_sram_raddr_b0    (o_sram_raddr_b0),
    .o_sram_raddr_b1    (o_sram_raddr_b1),
    .o_sram_raddr_b2    (o_sram_raddr_b2),
    .o_sram_raddr_b3    (o_sram_raddr_b3),
    .o_rdata_latch_en   (o_rdata_latch_en),
    .o_map_type_delay4  (o_map_type_delay4),
    .o_fmap_idx_delay4  (o_fmap_idx_delay4),
    .o_fwd_valid_delay4 (o_fwd_valid_delay4),
    .o_dbg_state        (o_dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t snap();
    return {o_busy, o_done, o_sram_rd_en, o_sram_raddr_b0, o_sram_raddr_b1,
            o_sram_raddr_b2, o_sram_raddr_b3, o_rdata_latch_en,
            o_map_type_delay4, o_fmap_idx_delay4, o_fwd_valid_delay4};
  endfunction

  // Reference bank address from the window corner and bank parity.
  function automatic logic [9:0] m_addr(input int wy, input int wx, input int py,
                                        input int px, input int blk);
    int y;
    int x;
    y = ((wy % 2) == py) ? wy : wy + 1;
    x = ((wx % 2) == px) ? wx : wx + 1;
    return 10'(((y / 2) * ((blk + 1) / 2) + (x / 2)) % 1024);
  endfunction

  // Reference model: the run is a list of (window, channel) items consumed one
  // per non-stalled cycle; the forwarded outputs are the item pushed 4 advances ago.
  task automatic build_expected(input int blk, input int ncyc, input int stall_lo,
                                input int stall_hi, input int srst_at,
                                input int restart_at, input int restart_blk);
    item_t items[$];
    hist_t hist[$];
    hist_t bub;
    int    phase;
    int    drain_left;
    bub = '0;
    hist = {bub, bub, bub, bub};
    items.delete();
    exp_q.delete();
    phase = 0;
    drain_left = 0;
    for (int c = 0; c < ncyc; c++) begin
      logic        st;
      logic        stalled;
      logic        start;
      int          sblk;
      logic        rd;
      logic        latch;
      logic [39:0] addrs;
      hist_t       s0;
      hist_t       d4;
      start   = (c == 0) || (c == restart_at);
      sblk    = (c == 0) ? blk : restart_blk;
      st      = (c >= stall_lo) && (c <= stall_hi);
      stalled = st && (phase == 1 || phase == 2);
      s0      = bub;
      rd      = 1'b0;
      addrs   = '0;
      if (phase == 1) begin
        addrs = items[0].addrs;
        if (!stalled) begin
          s0.v   = 1'b1;
          s0.map = items[0].map;
          s0.idx = items[0].ch;
          s0.l   = (items[0].ch == 7'd0);
          rd     = s0.l;
        end
      end
      latch = !stalled && hist[1].l;
      d4    = hist[0];
      exp_q.push_back({(phase != 0), (phase == 3), rd, addrs, latch, d4.map, d4.idx, d4.v});
      if (c == srst_at) begin
        hist  = {bub, bub, bub, bub};
        items.delete();
        phase = 0;
      end else begin
        if (!stalled) begin
          hist.push_back(s0);
          hist.delete(0);
        end
        case (phase)
          0: if (start) begin
            if (sblk < 2) phase = 3;
            else begin
              for (int wy = 0; wy <= sblk - 2; wy++)
                for (int wx = 0; wx <= sblk - 2; wx++)
                  for (int ch = 0; ch < CH; ch++) begin
                    item_t it;
                    it.map   = 2'((wy % 2) * 2 + (wx % 2));
                    it.ch    = 7'(ch);
                    it.addrs = {m_addr(wy, wx, 0, 0, sblk), m_addr(wy, wx, 0, 1, sblk),
                                m_addr(wy, wx, 1, 0, sblk), m_addr(wy, wx, 1, 1, sblk)};
                    items.push_back(it);
                  end
              phase = 1;
            end
          end
          1: if (!stalled) begin
            items.delete(0);
            if (items.size() == 0) begin
              phase = 2;
              drain_left = 4;
            end
          end
          2: if (!stalled) begin
            drain_left--;
            if (drain_left == 0) phase = 3;
          end
          default: phase = 0;
        endcase
      end
    end
  endtask

  // Driver: called just after a rising edge; cycle 0 carries the start pulse.
  task automatic drive_run(input int blk, input int ncyc, input int stall_lo,
                           input int stall_hi, input int srst_at,
                           input int restart_at, input int restart_blk);
    obs_q.delete();
    st_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      i_start       = (c == 0) || (c == restart_at);
      i_cfg_blk_num = 7'((c == 0) ? blk : restart_blk);
      i_stall       = (c >= stall_lo) && (c <= stall_hi);
      i_srst        = (c == srst_at);
      @(negedge clk);
      obs_q.push_back(snap());
      st_q.push_back(o_dbg_state);
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    i_stall = 1'b0;
    i_srst  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_both(input int blk, input int ncyc, input int stall_lo,
                          input int stall_hi, input int srst_at,
                          input int restart_at, input int restart_blk);
    build_expected(blk, ncyc, stall_lo, stall_hi, srst_at, restart_at, restart_blk);
    drive_run(blk, ncyc, stall_lo, stall_hi, srst_at, restart_at, restart_blk);
  endtask

  task automatic test_reset();
    i_srst  = 1'b1;
    i_start = 1'b1;
    i_cfg_blk_num = 7'd4;
    i_stall = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    i_srst  = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (snap() !== '0 || o_dbg_state !== IDLE_CODE) begin
      n_fail++;
      $display("FAIL reset_state: outputs %h state %0d, required 0 and %0d", snap(), o_dbg_state, IDLE_CODE);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    int errs = 0;
    int fb = -1, lb = -1, nb = 0, nrd = 0, frd = -1, lrd = -1, ffv = -1, lfv = -1, dc = -1;
    int gap_bad = 0, align_bad = 0, idx_bad = 0;
    run_both(4, 226, -1, -1, -1, -1, 0);
    for (int c = 0; c < 226; c++) begin
      n_tests++;
      if (obs_q[c] !== exp_q[c]) begin
        n_fail++;
        if (errs++ < 5) $display("FAIL nominal_cycle %0d: got %h required %h", c, obs_q[c], exp_q[c]);
      end
      if (obs_q[c][B_BUSY]) begin if (fb < 0) fb = c; lb = c; nb++; end
      if (obs_q[c][B_RD]) begin
        if (frd >= 0 && c - lrd != CH) gap_bad++;
        if (frd < 0) frd = c;
        lrd = c; nrd++;
        if (c + 4 < 226 && (obs_q[c+3][B_LATCH] !== 1'b1 || obs_q[c+4][7:1] !== 7'd0)) align_bad++;
      end
      if (obs_q[c][B_FV]) begin if (ffv < 0) ffv = c; lfv = c; end
      if (obs_q[c][B_DONE]) dc = c;
    end
    for (int k = 0; k < CH; k++) if (obs_q[5+k][7:1] !== 7'(k)) idx_bad++;
    n_tests++;
    if (fb != 1 || lb != 221 || nb != 221) begin
      n_fail++; $display("FAIL busy_window: got %0d..%0d (%0d) required 1..221 (221)", fb, lb, nb);
    end
    n_tests++;
    if (nrd != 9 || frd != 1 || lrd != 193 || gap_bad != 0) begin
      n_fail++; $display("FAIL rd_en_pulses: got %0d at %0d..%0d gaps_bad %0d required 9 at 1..193", nrd, frd, lrd, gap_bad);
    end
    n_tests++;
    if (ffv != 5 || lfv != 220) begin
      n_fail++; $display("FAIL fwd_valid_window: got %0d..%0d required 5..220", ffv, lfv);
    end
    n_tests++;
    if (dc != 221) begin n_fail++; $display("FAIL done_cycle: got %0d required 221", dc); end
    n_tests++;
    if (align_bad != 0) begin n_fail++; $display("FAIL latch_alignment: %0d bad windows required 0", align_bad); end
    n_tests++;
    if (idx_bad != 0) begin n_fail++; $display("FAIL fmap_idx_ramp: %0d bad required 0", idx_bad); end
    n_tests++;
    if (obs_q[1][50:11] !== 40'd0 || obs_q[5][9:8] !== 2'd0) begin
      n_fail++; $display("FAIL window_00: addr %h map %0d required 0 and 0", obs_q[1][50:11], obs_q[5][9:8]);
    end
    n_tests++;
    if (obs_q[25][50:11] !== {10'd1, 10'd0, 10'd1, 10'd0} || obs_q[29][9:8] !== 2'd1) begin
      n_fail++; $display("FAIL window_01: addr %h map %0d required 1,0,1,0 and 1", obs_q[25][50:11], obs_q[29][9:8]);
    end
    n_tests++;
    if (obs_q[97][50:11] !== {10'd3, 10'd2, 10'd1, 10'd0} || obs_q[101][9:8] !== 2'd3) begin
      n_fail++; $display("FAIL window_11: addr %h map %0d required 3,2,1,0 and 3", obs_q[97][50:11], obs_q[101][9:8]);
    end
  endtask

  task automatic test_stall();
    int errs = 0, dc = -1, strobe_bad = 0, frz_bad = 0;
    run_both(4, 231, 30, 34, -1, -1, 0);
    for (int c = 0; c < 231; c++) begin
      n_tests++;
      if (obs_q[c] !== exp_q[c]) begin
        n_fail++;
        if (errs++ < 5) $display("FAIL stall_cycle %0d: got %h required %h", c, obs_q[c], exp_q[c]);
      end
      if (obs_q[c][B_DONE]) dc = c;
    end
    for (int c = 30; c <= 34; c++) if (obs_q[c][B_RD] || obs_q[c][B_LATCH]) strobe_bad++;
    for (int c = 31; c <= 35; c++) if (obs_q[c][9:0] !== obs_q[30][9:0]) frz_bad++;
    n_tests++;
    if (dc != 226) begin n_fail++; $display("FAIL stall_done_cycle: got %0d required 226", dc); end
    n_tests++;
    if (strobe_bad != 0 || frz_bad != 0) begin
      n_fail++; $display("FAIL stall_hold: strobes %0d frozen_bad %0d required 0 0", strobe_bad, frz_bad);
    end
  endtask

  task automatic test_small_blk();
    for (int b = 0; b <= 2; b++) begin
      int n = (b < 2) ? 6 : 40;
      int errs = 0, ndone = 0, dc = -1, nrd = 0, nfv = 0;
      run_both(b, n, 2, 3, -1, -1, 0);
      for (int c = 0; c < n; c++) begin
        n_tests++;
        if (obs_q[c] !== exp_q[c]) begin
          n_fail++;
          if (errs++ < 5) $display("FAIL small_blk%0d_cycle %0d: got %h required %h", b, c, obs_q[c], exp_q[c]);
        end
        if (obs_q[c][B_DONE]) begin ndone++; dc = c; end
        if (obs_q[c][B_RD]) nrd++;
        if (obs_q[c][B_FV]) nfv++;
      end
      if (b < 2) begin
        n_tests++;
        if (ndone != 1 || dc < 1 || dc > 2 || nrd != 0 || nfv != 0) begin
          n_fail++; $display("FAIL small_blk%0d: done %0d at %0d rd %0d fv %0d required 1 done by cycle 2, no rd/fv", b, ndone, dc, nrd, nfv);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int errs = 0, dc = -1, nrd = 0;
    run_both(3, 104, -1, -1, -1, 10, 5);
    for (int c = 0; c < 104; c++) begin
      n_tests++;
      if (obs_q[c] !== exp_q[c]) begin
        n_fail++;
        if (errs++ < 5) $display("FAIL restart_cycle %0d: got %h required %h", c, obs_q[c], exp_q[c]);
      end
      if (obs_q[c][B_DONE]) dc = c;
      if (obs_q[c][B_RD]) nrd++;
    end
    n_tests++;
    if (dc != 101 || nrd != 4) begin
      n_fail++; $display("FAIL restart_ignored: done %0d rd %0d required 101 and 4", dc, nrd);
    end
  endtask

  task automatic test_reset_mid();
    int errs = 0;
    run_both(4, 52, 20, 22, 50, -1, 0);
    for (int c = 0; c <= 50; c++) begin
      n_tests++;
      if (obs_q[c] !== exp_q[c]) begin
        n_fail++;
        if (errs++ < 5) $display("FAIL midreset_cycle %0d: got %h required %h", c, obs_q[c], exp_q[c]);
      end
    end
    n_tests++;
    if (obs_q[51] !== '0 || st_q[51] !== IDLE_CODE) begin
      n_fail++; $display("FAIL midreset_after: outputs %h state %0d required 0 and %0d", obs_q[51], st_q[51], IDLE_CODE);
    end
    errs = 0;
    run_both(3, 104, -1, -1, -1, -1, 0);
    for (int c = 0; c < 104; c++) begin
      n_tests++;
      if (obs_q[c] !== exp_q[c]) begin
        n_fail++;
        if (errs++ < 5) $display("FAIL post_reset_cycle %0d: got %h required %h", c, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int b   = $urandom_range(2, 5);
      int slo = $urandom_range(0, 120);
      int sln = $urandom_range(0, 8);
      int n   = (b - 1) * (b - 1) * CH + 4 + 1 + sln + 4;
      int errs = 0;
      run_both(b, n, slo, slo + sln - 1, -1, -1, 0);
      for (int c = 0; c < n; c++) begin
        n_tests++;
        if (obs_q[c] !== exp_q[c]) begin
          n_fail++;
          if (errs++ < 5) $display("FAIL random%0d_blk%0d_cycle %0d: got %h required %h", r, b, c, obs_q[c], exp_q[c]);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_srst  = 1'b1;
    i_start = 1'b0;
    i_stall = 1'b0;
    i_cfg_blk_num = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_nominal();
    test_stall();
    test_small_blk();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
